// File: rtl/bip_pkg.sv
// Shared definitions for the accumulator CPU sequencer: field widths, opcodes,
// datapath select encodings, FSM states and the decoded control word.
package bip_pkg;

    localparam int BIP_PC_W    = 11;
    localparam int BIP_OP_W    = 5;
    localparam int BIP_OPND_W  = 11;
    localparam int BIP_INSTR_W = BIP_OP_W + BIP_OPND_W;

    localparam logic [BIP_OP_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [BIP_OP_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [BIP_OP_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [BIP_OP_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [BIP_OP_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [BIP_OP_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [BIP_OP_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [BIP_OP_W-1:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SEL_MEM = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_ALU = 2'd2;

    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       is_halt;
    } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Opcode to control-word decode. Purely combinational; the sequencer decides
// in which state each field is allowed to reach the datapath.
module bip_decoder
    import bip_pkg::*;
#(
    parameter int OP_W = BIP_OP_W
) (
    input  logic [OP_W-1:0] opcode_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OPC_HLT: begin
                ctrl_o.is_halt = 1'b1;
            end
            OPC_STO: begin
                ctrl_o.wr_ram = 1'b1;
            end
            OPC_LD: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_MEM;
                ctrl_o.rd_ram = 1'b1;
            end
            OPC_LDI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_IMM;
            end
            OPC_ADD: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_ALU;
                ctrl_o.sel_b  = SELB_MEM;
                ctrl_o.op     = OP_ADD;
                ctrl_o.rd_ram = 1'b1;
            end
            OPC_ADDI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_ALU;
                ctrl_o.sel_b  = SELB_IMM;
                ctrl_o.op     = OP_ADD;
            end
            OPC_SUB: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_ALU;
                ctrl_o.sel_b  = SELB_MEM;
                ctrl_o.op     = OP_SUB;
                ctrl_o.rd_ram = 1'b1;
            end
            OPC_SUBI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_ALU;
                ctrl_o.sel_b  = SELB_IMM;
                ctrl_o.op     = OP_SUB;
            end
            default: begin
                // unassigned opcodes fall through as NOP
            end
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator CPU; owns PC and IR.
//   state  | meaning
//   IDLE   | waiting for Start, PC=0
//   FETCH  | PmAddr=PC presented to program memory
//   DECODE | Instr valid; IR latched, data read issued for LD/ADD/SUB
//   EXEC   | single-cycle ACC/RAM strobes, PC advances unless HLT
//   HALT   | stopped until reset
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int PC_W   = BIP_PC_W,
    parameter int OP_W   = BIP_OP_W,
    parameter int OPND_W = BIP_OPND_W
) (
    input  logic                     clk,
    input  logic                     Reset_n,
    input  logic                     Start,
    input  logic [OP_W+OPND_W-1:0]   Instr,
    output logic [PC_W-1:0]          PmAddr,
    output logic [OPND_W-1:0]        Operand,
    output logic [1:0]               SelA,
    output logic                     SelB,
    output logic                     Op,
    output logic                     WrAcc,
    output logic                     ClrAcc,
    output logic                     RdRam,
    output logic                     WrRam,
    output logic                     Busy,
    output logic                     Halted
);

    localparam int INSTR_W = OP_W + OPND_W;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [OP_W-1:0]      dec_opc;
    ctrl_t                ctrl;

    // In DECODE the IR is not yet loaded, so decode straight from program memory.
    assign dec_opc = (state_q == ST_DECODE) ? Instr[INSTR_W-1 -: OP_W]
                                            : ir_q[INSTR_W-1 -: OP_W];

    bip_decoder #(
        .OP_W (OP_W)
    ) u_decoder (
        .opcode_i (dec_opc),
        .ctrl_o   (ctrl)
    );

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = Instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (ctrl.is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are masked by Reset_n so nothing fires in the cycle a reset lands.
    always_comb begin
        ClrAcc  = 1'b0;
        WrAcc   = 1'b0;
        WrRam   = 1'b0;
        RdRam   = 1'b0;
        SelA    = SEL_MEM;
        SelB    = SELB_MEM;
        Op      = OP_ADD;
        Busy    = 1'b0;
        Halted  = 1'b0;
        Operand = ir_q[OPND_W-1:0];
        case (state_q)
            ST_IDLE: begin
                ClrAcc = Start & Reset_n;
            end
            ST_FETCH: begin
                Busy = 1'b1;
            end
            ST_DECODE: begin
                Busy    = 1'b1;
                RdRam   = ctrl.rd_ram & Reset_n;
                Operand = Instr[OPND_W-1:0];
            end
            ST_EXEC: begin
                Busy  = 1'b1;
                WrAcc = ctrl.wr_acc & Reset_n;
                WrRam = ctrl.wr_ram & Reset_n;
                SelA  = ctrl.sel_a;
                SelB  = ctrl.sel_b;
                Op    = ctrl.op;
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign PmAddr = pc_q;

endmodule
